// File: rtl/uart_tx_parity_pkg.sv
// Shared UART definitions: transmit FSM encoding, frame constants and parity helper.
// Imported by both the transmit and receive sides of the UART.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_tx_state_t;

  localparam int DATA_BITS = 8;

  // Parity bit that makes the count of ones even (odd = 0) or odd (odd = 1)
  function automatic logic calcParity(input logic [DATA_BITS-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx_parity_if.sv
// Transmit request/status bundle between the UART top level and the transmitter.
interface uart_tx_parity_if;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;
  logic       tx_done;
  logic       tx;

  modport master (output tx_data, tx_start, input tx_busy, tx_done, tx);
  modport slave  (input tx_data, tx_start, output tx_busy, tx_done, tx);
endinterface

// File: rtl/uart_tx_parity_baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
// Shared by the transmitter and receiver.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);
  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count_r;

  // Bit-period counter; wraps by itself so back-to-back bits need no explicit clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r <= '0;
    end else if (clear) begin
      count_r <= '0;
    end else if (count_r == LAST) begin
      count_r <= '0;
    end else begin
      count_r <= count_r + CW'(1);
    end
  end

  assign tick = (count_r == LAST) && !clear;
endmodule

// File: rtl/uart_tx_parity.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity bit, one stop bit,
// with a busy/done handshake and a registered, glitch-free serial output.
module uart_tx_parity
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5208,
  parameter int PARITY_EN    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic               clk,
  input  logic               reset,
  uart_tx_parity_if.slave    bus
);
  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  uart_tx_state_t       state_r, nextState_s;
  logic [DATA_BITS-1:0] shift_r, nextShift_s;
  logic [2:0]           bitIdx_r, nextBitIdx_s;
  logic                 parity_r, nextParity_s;
  logic                 tx_r, nextTx_s;
  logic                 busy_r, nextBusy_s;
  logic                 done_r, nextDone_s;
  logic                 tick_s;
  logic                 accept_s;

  uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk   (clk),
    .reset (reset),
    .clear (state_r == IDLE),
    .tick  (tick_s)
  );

  // A request is taken when idle, or on the final stop-bit cycle so frames can abut
  assign accept_s = bus.tx_start && ((state_r == IDLE) || ((state_r == STOP) && tick_s));

  // State, datapath and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= IDLE;
      shift_r  <= '0;
      bitIdx_r <= 3'd0;
      parity_r <= 1'b0;
      tx_r     <= 1'b1;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r  <= nextState_s;
      shift_r  <= nextShift_s;
      bitIdx_r <= nextBitIdx_s;
      parity_r <= nextParity_s;
      tx_r     <= nextTx_s;
      busy_r   <= nextBusy_s;
      done_r   <= nextDone_s;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    nextState_s  = state_r;
    nextShift_s  = shift_r;
    nextBitIdx_s = bitIdx_r;
    nextParity_s = parity_r;
    nextTx_s     = tx_r;
    nextBusy_s   = busy_r;
    nextDone_s   = 1'b0;

    case (state_r)
      IDLE: begin
        nextTx_s   = 1'b1;
        nextBusy_s = 1'b0;
      end
      START: begin
        if (tick_s) begin
          nextState_s = DATA;
          nextTx_s    = shift_r[0];
        end else begin
          nextState_s = START;
        end
      end
      DATA: begin
        if (!tick_s) begin
          nextState_s = DATA;
        end else if (bitIdx_r == LAST_BIT) begin
          nextBitIdx_s = 3'd0;
          if (PARITY_EN != 0) begin
            nextState_s = PARITY;
            nextTx_s    = parity_r;
          end else begin
            nextState_s = STOP;
            nextTx_s    = 1'b1;
          end
        end else begin
          nextBitIdx_s = bitIdx_r + 3'd1;
          nextShift_s  = {1'b0, shift_r[DATA_BITS-1:1]};
          nextTx_s     = shift_r[1];
        end
      end
      PARITY: begin
        if (tick_s) begin
          nextState_s = STOP;
          nextTx_s    = 1'b1;
        end else begin
          nextState_s = PARITY;
        end
      end
      STOP: begin
        if (tick_s) begin
          nextState_s = IDLE;
          nextTx_s    = 1'b1;
          nextBusy_s  = 1'b0;
          nextDone_s  = 1'b1;
        end else begin
          nextState_s = STOP;
        end
      end
      default: begin
        nextState_s = IDLE;
        nextTx_s    = 1'b1;
        nextBusy_s  = 1'b0;
      end
    endcase

    if (accept_s) begin
      nextState_s  = START;
      nextShift_s  = bus.tx_data;
      nextParity_s = calcParity(bus.tx_data, 1'(PARITY_ODD));
      nextBitIdx_s = 3'd0;
      nextTx_s     = 1'b0;
      nextBusy_s   = 1'b1;
    end else begin
      nextParity_s = nextParity_s;
    end
  end

  assign bus.tx      = tx_r;
  assign bus.tx_busy = busy_r;
  assign bus.tx_done = done_r;
endmodule

// File: tb/tb_uart_tx_parity.sv
// Directed + randomized bench for uart_tx_parity: three instances (even, odd, no parity)
// checked cycle by cycle against a frame model built from the line protocol.
module tb_uart_tx_parity;
  localparam int CPB = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  logic       startV [3];
  logic [7:0] dataV  [3];

  uart_tx_parity_if ifA ();
  uart_tx_parity_if ifB ();
  uart_tx_parity_if ifC ();

  assign ifA.tx_start = startV[0];
  assign ifA.tx_data  = dataV[0];
  assign ifB.tx_start = startV[1];
  assign ifB.tx_data  = dataV[1];
  assign ifC.tx_start = startV[2];
  assign ifC.tx_data  = dataV[2];

  uart_tx_parity #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0)) dutEven (
    .clk(clk), .reset(reset), .bus(ifA));
  uart_tx_parity #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(1)) dutOdd (
    .clk(clk), .reset(reset), .bus(ifB));
  uart_tx_parity #(.CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0)) dutNoPar (
    .clk(clk), .reset(reset), .bus(ifC));

  always #5 clk = ~clk;

  function automatic logic txOf(input int sel);
    return (sel == 0) ? ifA.tx : (sel == 1) ? ifB.tx : ifC.tx;
  endfunction
  function automatic logic busyOf(input int sel);
    return (sel == 0) ? ifA.tx_busy : (sel == 1) ? ifB.tx_busy : ifC.tx_busy;
  endfunction
  function automatic logic doneOf(input int sel);
    return (sel == 0) ? ifA.tx_done : (sel == 1) ? ifB.tx_done : ifC.tx_done;
  endfunction

  // Expected line level for bit slot idx of a frame: start, data LSB first, parity, stop
  function automatic logic expBit(input logic [7:0] d, input bit pen, input bit podd, input int idx);
    int ones = $countones(d);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return d[idx-1];
    if (pen && idx == 9) return podd ? logic'((ones % 2) == 0) : logic'((ones % 2) == 1);
    return 1'b1;
  endfunction

  task automatic chk(input string tag, input int sel, input int cyc, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s dut%0d cyc%0d observed=%b expected=%b", tag, sel, cyc, obs, exp);
    end
  endtask

  task automatic checkIdle(input int sel, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      chk("idle_tx", sel, i, txOf(sel), 1'b1);
      chk("idle_busy", sel, i, busyOf(sel), 1'b0);
      chk("idle_done", sel, i, doneOf(sel), 1'b0);
    end
  endtask

  task automatic startSend(input int sel, input logic [7:0] d);
    @(negedge clk);
    dataV[sel]  = d;
    startV[sel] = 1'b1;
    @(posedge clk);
  endtask

  // mode 0: plain frame; 1: bogus request mid-frame; 2: keep requesting nextData back-to-back
  task automatic checkFrame(input int sel, input logic [7:0] d, input int mode,
                            input logic [7:0] nextData, input bit firstDone);
    bit pen  = (sel != 2);
    bit podd = (sel == 1);
    int nBits = pen ? 11 : 10;
    for (int k = 1; k <= nBits * CPB; k++) begin
      @(negedge clk);
      if (k == 1) begin
        if (mode == 2) begin
          dataV[sel] = nextData;
        end else begin
          startV[sel] = 1'b0;
          dataV[sel]  = 8'($urandom);
        end
      end
      if (mode == 1 && k == 20) begin
        startV[sel] = 1'b1;
        dataV[sel]  = 8'h3C;
      end
      if (mode == 1 && k == 21) startV[sel] = 1'b0;
      chk("frame_tx", sel, k, txOf(sel), expBit(d, pen, podd, (k - 1) / CPB));
      chk("frame_busy", sel, k, busyOf(sel), 1'b1);
      chk("frame_done", sel, k, doneOf(sel), logic'((k == 1) && firstDone));
    end
    if (mode != 2) begin
      @(negedge clk);
      chk("end_done", sel, 0, doneOf(sel), 1'b1);
      chk("end_busy", sel, 0, busyOf(sel), 1'b0);
      chk("end_tx", sel, 0, txOf(sel), 1'b1);
      checkIdle(sel, 1);
    end
  endtask

  initial begin
    logic [7:0] rv;
    for (int s = 0; s < 3; s++) begin
      startV[s] = 1'b0;
      dataV[s]  = 8'h00;
    end
    repeat (3) @(negedge clk);
    #1;
    chk("rst_tx", 0, 0, txOf(0), 1'b1);
    chk("rst_busy", 0, 0, busyOf(0), 1'b0);
    chk("rst_done", 0, 0, doneOf(0), 1'b0);
    reset = 1'b0;

    // Idle after reset
    for (int s = 0; s < 3; s++) checkIdle(s, (s == 0) ? 20 : 2);

    // 0xA5 even parity
    startSend(0, 8'hA5);
    checkFrame(0, 8'hA5, 0, 8'h00, 1'b0);

    // 0x07 with even, odd and no parity
    startSend(0, 8'h07);
    checkFrame(0, 8'h07, 0, 8'h00, 1'b0);
    startSend(1, 8'h07);
    checkFrame(1, 8'h07, 0, 8'h00, 1'b0);
    startSend(2, 8'h07);
    checkFrame(2, 8'h07, 0, 8'h00, 1'b0);

    // Request mid-frame is dropped; line stays idle afterwards
    startSend(0, 8'hA5);
    checkFrame(0, 8'hA5, 1, 8'h00, 1'b0);
    checkIdle(0, 50);

    // Held request: 0x55 then 0xAA with no gap, on parity and no-parity instances
    startSend(0, 8'h55);
    checkFrame(0, 8'h55, 2, 8'hAA, 1'b0);
    checkFrame(0, 8'hAA, 0, 8'h00, 1'b1);
    startSend(2, 8'h55);
    checkFrame(2, 8'h55, 2, 8'hAA, 1'b0);
    checkFrame(2, 8'hAA, 0, 8'h00, 1'b1);

    // Randomized words on every configuration
    for (int r = 0; r < 4; r++) begin
      for (int s = 0; s < 3; s++) begin
        rv = 8'($urandom);
        startSend(s, rv);
        checkFrame(s, rv, 0, 8'h00, 1'b0);
      end
    end

    // Reset during data bit 3 of 0xFF, then a clean 0x81 frame
    startSend(0, 8'hFF);
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      if (k == 1) startV[0] = 1'b0;
      chk("pre_rst_tx", 0, k, txOf(0), expBit(8'hFF, 1'b1, 1'b0, (k - 1) / CPB));
    end
    reset = 1'b1;
    #1;
    chk("midrst_tx", 0, 0, txOf(0), 1'b1);
    chk("midrst_busy", 0, 0, busyOf(0), 1'b0);
    chk("midrst_done", 0, 0, doneOf(0), 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    checkIdle(0, 10);
    startSend(0, 8'h81);
    checkFrame(0, 8'h81, 0, 8'h00, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
